// File: rtl/nios2_cpu_ocimem_ctrl.sv
// On-chip debug RAM controller: runs JTAG load/write/read commands and shares the RAM with a CPU port.
// Optional sticky dropped-command flag is built when OCIMEM_OVERRUN_DETECT_EN is defined.
module nios2_cpu_ocimem_ctrl #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  input  logic [ADDR_W-1:0] cpu_address,
  input  logic              cpu_read,
  input  logic              cpu_write,
  input  logic [DATA_W-1:0] cpu_writedata,
  output logic [DATA_W-1:0] cpu_readdata,
  output logic              cpu_waitrequest,
  output logic [DATA_W-1:0] MonDReg,
  output logic              mon_valid,
  output logic              jtag_overrun,
  output logic [1:0]        o_dbg_state,
  output logic [ADDR_W-1:0] o_dbg_jaddr
);

  localparam int DEPTH = 1 << ADDR_W;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_JRD  = 2'd1;
  localparam logic [1:0] S_CRD  = 2'd2;

  localparam logic [1:0] C_LOAD  = 2'd0;
  localparam logic [1:0] C_WRITE = 2'd1;
  localparam logic [1:0] C_READ  = 2'd2;

  logic [1:0]        r_state;
  logic [ADDR_W-1:0] r_jaddr;
  logic              r_pend_valid;
  logic [1:0]        r_pend_type;
  logic [DATA_W-1:0] r_mon;
  logic              r_mon_valid;
  logic [DATA_W-1:0] r_cpu_rdata;
  logic [DATA_W-1:0] r_q;
  logic [DATA_W-1:0] r_mem [0:DEPTH-1];

  logic              w_new;
  logic              w_multi;
  logic [1:0]        w_new_type;
  logic              w_idle;
  logic              w_cmd_valid;
  logic [1:0]        w_cmd_type;
  logic              w_drop;
  logic              w_clr_ovr;
  logic              w_ram_we;
  logic              w_ram_re;
  logic [ADDR_W-1:0] w_ram_addr;
  logic [DATA_W-1:0] w_ram_wdata;
  logic [1:0]        w_state_nxt;
  logic [ADDR_W-1:0] w_jaddr_nxt;
  logic              w_unused;

  // Handshake: the CPU master holds cpu_read/cpu_write and its address/data
  // until a cycle where cpu_waitrequest is 0; that cycle completes the access.
  always_comb begin
    w_new       = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
    w_multi     = (take_action_ocimem_a & take_action_ocimem_b) |
                  (take_action_ocimem_a & take_no_action_ocimem_a) |
                  (take_action_ocimem_b & take_no_action_ocimem_a);
    w_new_type  = take_action_ocimem_a ? C_LOAD : (take_action_ocimem_b ? C_WRITE : C_READ);
    w_idle      = (r_state == S_IDLE);
    w_cmd_valid = w_idle & (r_pend_valid | w_new);
    w_cmd_type  = r_pend_valid ? r_pend_type : w_new_type;
    w_drop      = w_new & (w_multi | (~w_idle & r_pend_valid));

    w_ram_we    = 1'b0;
    w_ram_re    = 1'b0;
    w_ram_addr  = cpu_address;
    w_ram_wdata = cpu_writedata;
    w_state_nxt = S_IDLE;
    w_jaddr_nxt = r_jaddr;
    w_clr_ovr   = 1'b0;

    if (w_cmd_valid) begin
      case (w_cmd_type)
        C_LOAD: begin
          w_jaddr_nxt = jdo[17 +: ADDR_W];
          w_ram_addr  = jdo[17 +: ADDR_W];
          w_clr_ovr   = jdo[37];
          if (jdo[34]) begin
            w_ram_re    = 1'b1;
            w_state_nxt = S_JRD;
          end
        end
        C_WRITE: begin
          w_ram_we    = 1'b1;
          w_ram_addr  = r_jaddr;
          w_ram_wdata = jdo[3 +: DATA_W];
          w_jaddr_nxt = r_jaddr + ADDR_W'(1);
        end
        default: begin
          w_ram_re    = 1'b1;
          w_ram_addr  = r_jaddr;
          w_jaddr_nxt = r_jaddr + ADDR_W'(1);
          w_state_nxt = S_JRD;
        end
      endcase
    end else if (w_idle && cpu_write) begin
      w_ram_we = 1'b1;
    end else if (w_idle && cpu_read) begin
      w_ram_re    = 1'b1;
      w_state_nxt = S_CRD;
    end

    if (w_idle) begin
      cpu_waitrequest = w_cmd_valid ? (cpu_read | cpu_write) : (~cpu_write & cpu_read);
    end else if (r_state == S_CRD) begin
      cpu_waitrequest = cpu_write;
    end else begin
      cpu_waitrequest = cpu_read | cpu_write;
    end
  end

  always_ff @(posedge clk) begin
    if (w_ram_we) r_mem[w_ram_addr] <= w_ram_wdata;
    if (w_ram_re) r_q <= r_mem[w_ram_addr];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_jaddr      <= '0;
      r_pend_valid <= 1'b0;
      r_pend_type  <= C_LOAD;
      r_mon        <= '0;
      r_mon_valid  <= 1'b0;
      r_cpu_rdata  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_jaddr     <= w_jaddr_nxt;
      r_mon_valid <= (r_state == S_JRD);
      if (r_state == S_JRD) r_mon <= r_q;
      if (r_state == S_CRD) r_cpu_rdata <= r_q;
      // jdo is not captured: the debug slave holds it until the command is serviced.
      if (w_idle) begin
        r_pend_valid <= r_pend_valid & w_new;
        r_pend_type  <= w_new_type;
      end else if (!r_pend_valid && w_new) begin
        r_pend_valid <= 1'b1;
        r_pend_type  <= w_new_type;
      end
    end
  end

`ifdef OCIMEM_OVERRUN_DETECT_EN
  logic r_overrun;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_overrun <= 1'b0;
    end else if (w_drop) begin
      r_overrun <= 1'b1;
    end else if (w_clr_ovr) begin
      r_overrun <= 1'b0;
    end
  end

  assign jtag_overrun = r_overrun;
  assign w_unused     = ^{jdo[36:35], jdo[2:0]};
`else
  assign jtag_overrun = 1'b0;
  assign w_unused     = ^{jdo[37:35], jdo[2:0], w_drop, w_clr_ovr};
`endif

  assign cpu_readdata = (r_state == S_CRD) ? r_q : r_cpu_rdata;
  assign MonDReg      = r_mon;
  assign mon_valid    = r_mon_valid;
  assign o_dbg_state  = r_state;
  assign o_dbg_jaddr  = r_jaddr;

endmodule

// File: tb/tb_nios2_cpu_ocimem_ctrl.sv
// Directed bench for nios2_cpu_ocimem_ctrl: JTAG/CPU read data is scoreboarded through expected queues.
module tb_nios2_cpu_ocimem_ctrl;
  localparam int ADDR_W = 8;

  logic              clk;
  logic              reset;
  logic [37:0]       jdo;
  logic              ta_a;
  logic              ta_b;
  logic              tna_a;
  logic [ADDR_W-1:0] cpu_address;
  logic              cpu_read;
  logic              cpu_write;
  logic [31:0]       cpu_writedata;
  logic [31:0]       cpu_readdata;
  logic              cpu_waitrequest;
  logic [31:0]       mon_dreg;
  logic              mon_valid;
  logic              jtag_overrun;
  logic [1:0]        dbg_state;
  logic [ADDR_W-1:0] dbg_jaddr;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] mon_q[$];
  logic [31:0] cpu_q[$];
  logic [31:0] exp_ovr;

  nios2_cpu_ocimem_ctrl #(.ADDR_W(ADDR_W), .DATA_W(32)) dut (
    .clk                     (clk),
    .reset                   (reset),
    .jdo                     (jdo),
    .take_action_ocimem_a    (ta_a),
    .take_action_ocimem_b    (ta_b),
    .take_no_action_ocimem_a (tna_a),
    .cpu_address             (cpu_address),
    .cpu_read                (cpu_read),
    .cpu_write               (cpu_write),
    .cpu_writedata           (cpu_writedata),
    .cpu_readdata            (cpu_readdata),
    .cpu_waitrequest         (cpu_waitrequest),
    .MonDReg                 (mon_dreg),
    .mon_valid               (mon_valid),
    .jtag_overrun            (jtag_overrun),
    .o_dbg_state             (dbg_state),
    .o_dbg_jaddr             (dbg_jaddr)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (mon_valid) begin
      if (mon_q.size() == 0) check("mon_valid_unexpected", 32'd1, 32'd0);
      else check("mon_data", mon_dreg, mon_q.pop_front());
    end
    if (cpu_read && !cpu_waitrequest) begin
      if (cpu_q.size() == 0) check("cpu_rd_unexpected", 32'd1, 32'd0);
      else check("cpu_rdata", cpu_readdata, cpu_q.pop_front());
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input int kind, input logic [37:0] v);
    jdo = v;
    case (kind)
      0:       ta_a  = 1'b1;
      1:       ta_b  = 1'b1;
      default: tna_a = 1'b1;
    endcase
    tick();
    ta_a  = 1'b0;
    ta_b  = 1'b0;
    tna_a = 1'b0;
  endtask

  function automatic logic [37:0] mk_load(input logic [7:0] a, input logic rd, input logic clr);
    logic [37:0] r;
    r         = '0;
    r[24:17]  = a;
    r[34]     = rd;
    r[37]     = clr;
    return r;
  endfunction

  function automatic logic [37:0] mk_write(input logic [31:0] d);
    logic [37:0] r;
    r       = '0;
    r[34:3] = d;
    return r;
  endfunction

  initial begin
`ifdef OCIMEM_OVERRUN_DETECT_EN
    exp_ovr = 32'd1;
`else
    exp_ovr = 32'd0;
`endif
    reset = 1'b1; jdo = '0; ta_a = 1'b0; ta_b = 1'b0; tna_a = 1'b0;
    cpu_address = '0; cpu_read = 1'b0; cpu_write = 1'b0; cpu_writedata = '0;
    repeat (3) tick();
    check("rst_mondreg", mon_dreg, 32'd0);
    check("rst_mon_valid", 32'(mon_valid), 32'd0);
    check("rst_waitreq", 32'(cpu_waitrequest), 32'd0);
    check("rst_overrun", 32'(jtag_overrun), 32'd0);
    check("rst_jaddr", 32'(dbg_jaddr), 32'd0);
    check("rst_cpu_rdata", cpu_readdata, 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    reset = 1'b0;
    tick();

    // load + two writes
    strobe(0, mk_load(8'h10, 1'b0, 1'b0));
    strobe(1, mk_write(32'hDEADBEEF));
    strobe(1, mk_write(32'h12345678));
    check("t1_jaddr", 32'(dbg_jaddr), 32'h12);
    check("t1_state_idle", 32'(dbg_state), 32'd0);

    // load with read, then two reads
    mon_q.push_back(32'hDEADBEEF);
    strobe(0, mk_load(8'h10, 1'b1, 1'b0));
    check("t2_state_jrd", 32'(dbg_state), 32'd1);
    check("t2_no_early_valid", 32'(mon_valid), 32'd0);
    check("t2_jaddr_hold", 32'(dbg_jaddr), 32'h10);
    tick();
    check("t2_valid_pulse", 32'(mon_valid), 32'd1);
    check("t2_mondreg", mon_dreg, 32'hDEADBEEF);
    tick();
    check("t2_valid_one_cycle", 32'(mon_valid), 32'd0);
    mon_q.push_back(32'hDEADBEEF);
    strobe(2, jdo);
    tick();
    mon_q.push_back(32'h12345678);
    strobe(2, jdo);
    tick(); tick();
    check("t2_jaddr", 32'(dbg_jaddr), 32'h12);

    // wrap at top of RAM
    cpu_write = 1'b1; cpu_address = 8'h00; cpu_writedata = 32'h00000C0D;
    #1 check("t3_cpu_wr_nowait", 32'(cpu_waitrequest), 32'd0);
    tick();
    cpu_write = 1'b0;
    strobe(0, mk_load(8'hFF, 1'b0, 1'b0));
    strobe(1, mk_write(32'hA5A5A5A5));
    check("t3_jaddr_wrap", 32'(dbg_jaddr), 32'h00);
    mon_q.push_back(32'h00000C0D);
    strobe(2, jdo);
    tick(); tick();
    check("t3_jaddr_after_rd", 32'(dbg_jaddr), 32'h01);
    mon_q.push_back(32'hA5A5A5A5);
    strobe(0, mk_load(8'hFF, 1'b1, 1'b0));
    tick(); tick();

    // CPU write contending with a JTAG write
    strobe(0, mk_load(8'h20, 1'b0, 1'b0));
    jdo = mk_write(32'h11112222); ta_b = 1'b1;
    cpu_write = 1'b1; cpu_address = 8'h30; cpu_writedata = 32'h33334444;
    #1 check("tc_wr_contended", 32'(cpu_waitrequest), 32'd1);
    tick();
    ta_b = 1'b0;
    #1 check("tc_wr_free", 32'(cpu_waitrequest), 32'd0);
    tick();
    cpu_write = 1'b0;
    mon_q.push_back(32'h11112222);
    strobe(0, mk_load(8'h20, 1'b1, 1'b0));
    tick(); tick();
    cpu_read = 1'b1; cpu_address = 8'h30;
    cpu_q.push_back(32'h33334444);
    #1 check("tc_rd_issue_wait", 32'(cpu_waitrequest), 32'd1);
    tick();
    check("tc_rd_crd_nowait", 32'(cpu_waitrequest), 32'd0);
    tick();
    cpu_read = 1'b0;

    // CPU read with a JTAG read arriving in its CRD cycle
    strobe(0, mk_load(8'h10, 1'b0, 1'b0));
    cpu_read = 1'b1; cpu_address = 8'h11;
    cpu_q.push_back(32'h12345678);
    #1 check("t4_rd_issue_wait", 32'(cpu_waitrequest), 32'd1);
    tick();
    tna_a = 1'b1;
    mon_q.push_back(32'hDEADBEEF);
    #1 check("t4_crd_nowait", 32'(cpu_waitrequest), 32'd0);
    tick();
    cpu_read = 1'b0; tna_a = 1'b0;
    check("t4_pending_idle", 32'(dbg_state), 32'd0);
    check("t4_jaddr_pre", 32'(dbg_jaddr), 32'h10);
    tick();
    check("t4_pending_issued", 32'(dbg_state), 32'd1);
    check("t4_jaddr_post", 32'(dbg_jaddr), 32'h11);
    check("t4_no_overrun", 32'(jtag_overrun), 32'd0);
    tick(); tick();

    // overrun: fill the pending slot, then one more strobe
    strobe(0, mk_load(8'h12, 1'b0, 1'b0));
    strobe(1, mk_write(32'h00000012));
    strobe(1, mk_write(32'h00000013));
    strobe(0, mk_load(8'h10, 1'b0, 1'b0));
    mon_q.push_back(32'hDEADBEEF);
    strobe(2, jdo);
    mon_q.push_back(32'h12345678);
    strobe(2, jdo);
    check("t5_ovr_after_pend", 32'(jtag_overrun), 32'd0);
    mon_q.push_back(32'h00000012);
    strobe(2, jdo);
    check("t5_ovr_after_relatch", 32'(jtag_overrun), 32'd0);
    strobe(2, jdo);
    check("t5_ovr_set", 32'(jtag_overrun), exp_ovr);
    repeat (4) tick();
    check("t5_jaddr_drained", 32'(dbg_jaddr), 32'h13);
    check("t5_ovr_sticky", 32'(jtag_overrun), exp_ovr);
    strobe(0, mk_load(8'h00, 1'b0, 1'b1));
    check("t5_ovr_cleared", 32'(jtag_overrun), 32'd0);
    check("t5_jaddr_load0", 32'(dbg_jaddr), 32'h00);

    // reset during JRD
    strobe(0, mk_load(8'h10, 1'b1, 1'b0));
    check("t6_in_jrd", 32'(dbg_state), 32'd1);
    reset = 1'b1;
    tick();
    check("t6_no_mon_valid", 32'(mon_valid), 32'd0);
    check("t6_mondreg_clr", mon_dreg, 32'd0);
    check("t6_jaddr_clr", 32'(dbg_jaddr), 32'd0);
    check("t6_state_idle", 32'(dbg_state), 32'd0);
    check("t6_waitreq", 32'(cpu_waitrequest), 32'd0);
    reset = 1'b0;
    tick(); tick();
    check("t6_still_no_valid", 32'(mon_valid), 32'd0);

    // final report
    check("mon_q_drained", 32'(mon_q.size()), 32'd0);
    check("cpu_q_drained", 32'(cpu_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
